// File: rtl/ram_arbiter.sv
// Single-port RAM sequencer for VDG fetch, CPU access and a FIFO-buffered loader.
// Optional macro RAM_ARB_ROM_WP_EN blocks CPU writes to the upper half (ROM space).
module ram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_ena,
  input  logic              vdg_req,
  input  logic [ADDR_W-1:0] vdg_addr,
  output logic [DATA_W-1:0] vdg_rdata,
  output logic              vdg_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              ld_wr,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_full,
  output logic              ld_ovf,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_CAPTURE} state_t;
  typedef enum logic [1:0] {G_NONE, G_VDG, G_CPU, G_LD} gnt_t;

  state_t state_q, state_d;
  gnt_t   gnt_q, gnt_sel;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              cpu_wr_q;
  logic [DATA_W-1:0] vdg_rdata_q, cpu_rdata_q;
  logic              vdg_valid_q, cpu_ack_q;
  logic              ovf_q;
  logic [SC_W-1:0]   starve_q;

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic fifo_empty, fifo_full, push, pop, arb, grant, cpu_we_eff;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign push       = ld_wr && !fifo_full;
  assign pop        = (state_q == S_CAPTURE) && (gnt_q == G_LD);
  assign arb        = (state_q == S_IDLE) && clk_ena;
  assign grant      = arb && (gnt_sel != G_NONE);

`ifdef RAM_ARB_ROM_WP_EN
  assign cpu_we_eff = cpu_we && !cpu_addr[ADDR_W-1];
`else
  assign cpu_we_eff = cpu_we;
`endif

  // A starved loader entry outranks the CPU but never the display fetch.
  always_comb begin
    gnt_sel = G_NONE;
    if (vdg_req)                                           gnt_sel = G_VDG;
    else if (!fifo_empty && starve_q == SC_W'(STARVE_MAX)) gnt_sel = G_LD;
    else if (cpu_req)                                      gnt_sel = G_CPU;
    else if (!fifo_empty)                                  gnt_sel = G_LD;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (grant) state_d = S_ACCESS;
      S_ACCESS:  state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      gnt_q       <= G_NONE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      cpu_wr_q    <= 1'b0;
      vdg_rdata_q <= '0;
      cpu_rdata_q <= '0;
      vdg_valid_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ovf_q       <= 1'b0;
      starve_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      vdg_valid_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      if (grant) begin
        gnt_q    <= gnt_sel;
        cpu_wr_q <= cpu_we;
        case (gnt_sel)
          G_VDG: begin addr_q <= vdg_addr; wdata_q <= '0; we_q <= 1'b0; end
          G_CPU: begin addr_q <= cpu_addr; wdata_q <= cpu_wdata; we_q <= cpu_we_eff; end
          default: begin
            addr_q  <= fifo_addr_q[rd_ptr_q];
            wdata_q <= fifo_data_q[rd_ptr_q];
            we_q    <= 1'b1;
          end
        endcase
      end
      if (state_q == S_CAPTURE) begin
        if (gnt_q == G_VDG) begin
          vdg_rdata_q <= ram_rdata;
          vdg_valid_q <= 1'b1;
        end else if (gnt_q == G_CPU) begin
          if (!cpu_wr_q) cpu_rdata_q <= ram_rdata;
          cpu_ack_q <= 1'b1;
        end
      end
      if (ld_wr && fifo_full) ovf_q <= 1'b1;
      if (fifo_empty) starve_q <= '0;
      else if (grant) begin
        if (gnt_sel == G_LD)                    starve_q <= '0;
        else if (starve_q != SC_W'(STARVE_MAX)) starve_q <= starve_q + SC_W'(1);
      end
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= ld_addr;
      fifo_data_q[wr_ptr_q] <= ld_data;
    end
  end

  assign ram_addr  = (state_q == S_ACCESS) ? addr_q  : '0;
  assign ram_wdata = (state_q == S_ACCESS) ? wdata_q : '0;
  assign ram_we    = (state_q == S_ACCESS) && we_q;
  assign busy      = (state_q != S_IDLE);
  assign vdg_rdata = vdg_rdata_q;
  assign vdg_valid = vdg_valid_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign ld_full   = fifo_full;
  assign ld_ovf    = ovf_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a 1-clk-latency RAM model and loader write scoreboard.
module tb_ram_arbiter;
  logic        clk = 1'b0;
  logic        reset, clk_ena;
  logic        vdg_req, vdg_valid;
  logic [15:0] vdg_addr;
  logic [7:0]  vdg_rdata;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        ld_wr, ld_full, ld_ovf;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        busy;

  ram_arbiter dut (
    .clk(clk), .reset(reset), .clk_ena(clk_ena),
    .vdg_req(vdg_req), .vdg_addr(vdg_addr), .vdg_rdata(vdg_rdata), .vdg_valid(vdg_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data), .ld_full(ld_full), .ld_ovf(ld_ovf),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy)
  );

  // clock / RAM model
  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // scoreboard
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc_n    = 0;
  int          we_cnt   = 0;
  bit          ena_run  = 1'b0;
  bit          sb_en    = 1'b0;
  logic [23:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (ram_we) we_cnt++;
    if (sb_en && ram_we) begin
      logic [23:0] e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 24'hFFFFFF;
      chk("ld_write", {8'h00, ram_addr, ram_wdata}, {8'h00, e});
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    cyc_n++;
    if (ena_run) clk_ena = (cyc_n % 4 == 0);
  endtask

  task automatic wait_ena();
    int n = 0;
    while (!clk_ena && n < 16) begin
      tick();
      n++;
    end
    chk("ena_seen", {31'b0, clk_ena}, 32'd1);
  endtask

  task automatic cpu_set(input logic we, input logic [15:0] a, input logic [7:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  int   we_base;
  logic exp_rom_we;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i[7:0] ^ i[15:8]);
    reset = 1'b1; clk_ena = 1'b0;
    vdg_req = 1'b0; vdg_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ld_wr = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) tick();
    chk("rst_ram_we", {31'b0, ram_we}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_cpu_rdata", {24'b0, cpu_rdata}, 0);
    chk("rst_vdg_rdata", {24'b0, vdg_rdata}, 0);
    chk("rst_ld_full", {31'b0, ld_full}, 0);

    // reset in the middle of a CPU write access
    reset = 1'b0; clk_ena = 1'b1;
    cpu_set(1'b1, 16'h4000, 8'h77);
    tick();
    clk_ena = 1'b0;
    chk("mid_ram_we", {31'b0, ram_we}, 1);
    chk("mid_busy", {31'b0, busy}, 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_we", {31'b0, ram_we}, 0);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    tick();
    chk("mid_rst_ack", {31'b0, cpu_ack}, 0);
    chk("mid_rst_ovf", {31'b0, ld_ovf}, 0);
    chk("mid_rst_full", {31'b0, ld_full}, 0);
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    chk("mid_no_ack", {31'b0, cpu_ack}, 0);

    // CPU write then read, clk_ena every 4th clk
    ena_run = 1'b1;
    we_base = we_cnt;
    wait_ena();
    cpu_set(1'b1, 16'h1234, 8'hA5);
    tick();
    chk("wr_addr", {16'b0, ram_addr}, 32'h1234);
    chk("wr_we", {31'b0, ram_we}, 1);
    chk("wr_wdata", {24'b0, ram_wdata}, 32'hA5);
    tick();
    chk("wr_ack_early", {31'b0, cpu_ack}, 0);
    tick();
    chk("wr_ack", {31'b0, cpu_ack}, 1);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    chk("wr_ack_pulse", {31'b0, cpu_ack}, 0);
    wait_ena();
    cpu_set(1'b0, 16'h1234, 8'h00);
    tick();
    chk("rd_we", {31'b0, ram_we}, 0);
    tick();
    tick();
    chk("rd_ack", {31'b0, cpu_ack}, 1);
    chk("rd_data", {24'b0, cpu_rdata}, 32'hA5);
    cpu_req = 1'b0;
    chk("wr_pulse_count", we_cnt - we_base, 1);

    // VDG and CPU at the same edge: VDG first
    wait_ena();
    vdg_req = 1'b1; vdg_addr = 16'h0234;
    cpu_set(1'b0, 16'h1234, 8'h00);
    tick();
    chk("both_addr_vdg", {16'b0, ram_addr}, 32'h0234);
    tick();
    tick();
    chk("both_vdg_valid", {31'b0, vdg_valid}, 1);
    chk("both_vdg_data", {24'b0, vdg_rdata}, 32'h36);
    chk("both_cpu_wait", {31'b0, cpu_ack}, 0);
    vdg_req = 1'b0;
    wait_ena();
    tick();
    chk("both_addr_cpu", {16'b0, ram_addr}, 32'h1234);
    tick();
    tick();
    chk("both_cpu_ack", {31'b0, cpu_ack}, 1);
    chk("both_cpu_data", {24'b0, cpu_rdata}, 32'hA5);
    cpu_req = 1'b0;

    // loader starvation against a continuous CPU
    ld_wr = 1'b1; ld_addr = 16'h2000; ld_data = 8'h5A;
    tick();
    ld_wr = 1'b0;
    cpu_set(1'b0, 16'h1234, 8'h00);
    for (int g = 1; g <= 9; g++) begin
      wait_ena();
      tick();
      chk("starve_we", {31'b0, ram_we}, {31'b0, g == 9});
      if (g == 9) begin
        chk("starve_addr", {16'b0, ram_addr}, 32'h2000);
        chk("starve_data", {24'b0, ram_wdata}, 32'h5A);
      end
    end
    cpu_req = 1'b0;
    repeat (3) tick();
    chk("starve_mem", {24'b0, mem[16'h2000]}, 32'h5A);

    // fill the loader FIFO with arbitration stopped, then drain in order
    ena_run = 1'b0; clk_ena = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 5; i++) begin
      ld_wr = 1'b1; ld_addr = 16'h3000 + 16'(i); ld_data = 8'hC0 + 8'(i);
      if (i < 4) exp_q.push_back({ld_addr, ld_data});
      tick();
      chk("fill_full", {31'b0, ld_full}, {31'b0, i >= 3});
      chk("fill_ovf", {31'b0, ld_ovf}, {31'b0, i == 4});
    end
    ld_wr = 1'b0;
    sb_en = 1'b1;
    ena_run = 1'b1;
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) tick();
    repeat (3) tick();
    sb_en = 1'b0;
    chk("drain_left", exp_q.size(), 0);
    chk("drain_full", {31'b0, ld_full}, 0);
    chk("drain_ovf_sticky", {31'b0, ld_ovf}, 1);

    // CPU write into ROM space
`ifdef RAM_ARB_ROM_WP_EN
    exp_rom_we = 1'b0;
`else
    exp_rom_we = 1'b1;
`endif
    wait_ena();
    cpu_set(1'b1, 16'h8000, 8'h55);
    tick();
    chk("rom_addr", {16'b0, ram_addr}, 32'h8000);
    chk("rom_we", {31'b0, ram_we}, {31'b0, exp_rom_we});
    tick();
    tick();
    chk("rom_ack", {31'b0, cpu_ack}, 1);
    chk("rom_rdata_hold", {24'b0, cpu_rdata}, 32'hA5);
    cpu_req = 1'b0; cpu_we = 1'b0;

    // final reset clears sticky overflow and data
    reset = 1'b1;
    tick();
    chk("end_ovf", {31'b0, ld_ovf}, 0);
    chk("end_cpu_rdata", {24'b0, cpu_rdata}, 0);
    chk("end_vdg_rdata", {24'b0, vdg_rdata}, 0);
    chk("end_busy", {31'b0, busy}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
